// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared state encoding and bus constants for the I2C target memory.
package i2c_tgt_pkg;

   localparam int   BYTE_BITS = 8;
   localparam logic ACK       = 1'b0;
   localparam logic NACK      = 1'b1;
   localparam logic RW_WRITE  = 1'b0;
   localparam logic RW_READ   = 1'b1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DEV_ADDR,
      S_DEV_ACK,
      S_ADDR_HI,
      S_ACK_HI,
      S_ADDR_LO,
      S_ACK_LO,
      S_WR_DATA,
      S_WR_ACK,
      S_RD_DATA,
      S_RD_ACK
   } state_t;

endpackage

// File: rtl/i2c_tgt_busmon.sv
// i2c_tgt_busmon: pad synchronizers and SCL edge / START / STOP detection.
module i2c_tgt_busmon
   import i2c_tgt_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic o_sda,
   output logic o_scl_rise,
   output logic o_scl_fall,
   output logic o_start,
   output logic o_stop
);

   logic [1:0] r_scl_sync;
   logic [1:0] r_sda_sync;
   logic       r_scl_d;
   logic       r_sda_d;
   logic       w_scl;
   logic       w_sda;

   // Idle bus level is high on both lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_d    <= 1'b1;
         r_sda_d    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], scl_i};
         r_sda_sync <= {r_sda_sync[0], sda_i};
         r_scl_d    <= r_scl_sync[1];
         r_sda_d    <= r_sda_sync[1];
      end
   end

   assign w_scl      = r_scl_sync[1];
   assign w_sda      = r_sda_sync[1];
   assign o_sda      = w_sda;
   assign o_scl_rise = w_scl & ~r_scl_d;
   assign o_scl_fall = ~w_scl & r_scl_d;
   assign o_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign o_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target with 2-byte word addressing over an internal byte memory.
// Optional write protect input is enabled by defining I2C_TGT_WP_EN.
module i2c_target_mem
   import i2c_tgt_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = 7'h50,
   parameter int         AW       = 8,
   parameter logic [7:0] RST_VAL  = 8'h00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scl_i,
   input  logic          sda_i,
   output logic          sda_oe,
   output logic          busy,
   output logic          wr_stb,
   output logic [AW-1:0] wr_idx,
   output logic [7:0]    wr_data
`ifdef I2C_TGT_WP_EN
   ,
   input  logic          wp
`endif
);

   localparam int DEPTH = 1 << AW;

   logic          w_sda;
   logic          w_rise;
   logic          w_fall;
   logic          w_start;
   logic          w_stop;
   logic          w_wp;
   logic          w_last;
   logic [7:0]    w_byte;
   logic [15:0]   w_addr;

   state_t        r_state;
   logic [2:0]    r_bcnt;
   logic [7:0]    r_sh;
   logic [7:0]    r_tx;
   logic [7:0]    r_hi;
   logic [AW-1:0] r_ptr;
   logic          r_rw;
   logic          r_ph;
   logic          r_ack_drv;
   logic          r_sda_oe;
   logic          r_busy;
   logic          r_wr_stb;
   logic [AW-1:0] r_wr_idx;
   logic [7:0]    r_wr_data;
   logic [7:0]    r_mem [DEPTH];

   i2c_tgt_busmon u_busmon (
      .clk        (clk),
      .rst        (rst),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .o_sda      (w_sda),
      .o_scl_rise (w_rise),
      .o_scl_fall (w_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
   );

`ifdef I2C_TGT_WP_EN
   assign w_wp = wp;
`else
   assign w_wp = 1'b0;
`endif

   assign w_byte = {r_sh[6:0], w_sda};
   assign w_last = (r_bcnt == 3'(BYTE_BITS - 1));
   assign w_addr = {r_hi, w_byte};

   // r_ph marks the second SCL fall of an ACK slot (or a master ACK in RD_ACK).
   always_ff @(posedge clk) begin
      r_wr_stb <= 1'b0;
      if (rst) begin
         r_state   <= S_IDLE;
         r_bcnt    <= '0;
         r_sh      <= '0;
         r_tx      <= '0;
         r_hi      <= '0;
         r_ptr     <= '0;
         r_rw      <= RW_WRITE;
         r_ph      <= 1'b0;
         r_ack_drv <= 1'b0;
         r_sda_oe  <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_idx  <= '0;
         r_wr_data <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= RST_VAL;
      end else if (w_stop) begin
         r_state  <= S_IDLE;
         r_sda_oe <= 1'b0;
         r_busy   <= 1'b0;
         r_ph     <= 1'b0;
      end else if (w_start) begin
         r_state  <= S_DEV_ADDR;
         r_bcnt   <= '0;
         r_sda_oe <= 1'b0;
         r_ph     <= 1'b0;
      end else begin
         unique case (r_state)
            S_DEV_ADDR, S_ADDR_HI, S_ADDR_LO, S_WR_DATA: begin
               if (w_rise) begin
                  r_sh   <= w_byte;
                  r_bcnt <= r_bcnt + 3'd1;
                  if (w_last) begin
                     r_ph      <= 1'b0;
                     r_ack_drv <= 1'b1;
                     if (r_state == S_DEV_ADDR) begin
                        if (w_byte[7:1] == DEV_ADDR) begin
                           r_busy  <= 1'b1;
                           r_rw    <= w_byte[0];
                           r_tx    <= r_mem[r_ptr];
                           r_state <= S_DEV_ACK;
                        end else begin
                           r_busy  <= 1'b0;
                           r_state <= S_IDLE;
                        end
                     end else if (r_state == S_ADDR_HI) begin
                        r_hi    <= w_byte;
                        r_state <= S_ACK_HI;
                     end else if (r_state == S_ADDR_LO) begin
                        r_ptr   <= w_addr[AW-1:0];
                        r_state <= S_ACK_LO;
                     end else begin
                        if (w_wp) begin
                           r_ack_drv <= 1'b0;
                        end else begin
                           r_mem[r_ptr] <= w_byte;
                           r_wr_stb     <= 1'b1;
                           r_wr_idx     <= r_ptr;
                           r_wr_data    <= w_byte;
                        end
                        r_ptr   <= r_ptr + AW'(1);
                        r_state <= S_WR_ACK;
                     end
                  end
               end
            end
            S_DEV_ACK, S_ACK_HI, S_ACK_LO, S_WR_ACK: begin
               if (w_fall) begin
                  if (!r_ph) begin
                     r_ph     <= 1'b1;
                     r_sda_oe <= r_ack_drv;
                  end else begin
                     r_ph     <= 1'b0;
                     r_bcnt   <= '0;
                     r_sda_oe <= 1'b0;
                     if (r_state == S_DEV_ACK) begin
                        if (r_rw == RW_READ) begin
                           r_state  <= S_RD_DATA;
                           r_sda_oe <= ~r_tx[7];
                        end else begin
                           r_state <= S_ADDR_HI;
                        end
                     end else if (r_state == S_ACK_HI) begin
                        r_state <= S_ADDR_LO;
                     end else begin
                        r_state <= S_WR_DATA;
                     end
                  end
               end
            end
            S_RD_DATA: begin
               if (w_rise) begin
                  r_bcnt <= r_bcnt + 3'd1;
               end else if (w_fall) begin
                  if (r_bcnt == 3'd0) begin
                     r_sda_oe <= 1'b0;
                     r_ptr    <= r_ptr + AW'(1);
                     r_ph     <= 1'b0;
                     r_state  <= S_RD_ACK;
                  end else begin
                     r_tx     <= {r_tx[6:0], 1'b0};
                     r_sda_oe <= ~r_tx[6];
                  end
               end
            end
            S_RD_ACK: begin
               if (w_rise) begin
                  if (w_sda == ACK) begin
                     r_tx <= r_mem[r_ptr];
                     r_ph <= 1'b1;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else if (w_fall && r_ph) begin
                  r_ph     <= 1'b0;
                  r_bcnt   <= '0;
                  r_sda_oe <= ~r_tx[7];
                  r_state  <= S_RD_DATA;
               end
            end
            default: begin
               r_sda_oe <= 1'b0;
            end
         endcase
      end
   end

   assign sda_oe  = r_sda_oe;
   assign busy    = r_busy;
   assign wr_stb  = r_wr_stb;
   assign wr_idx  = r_wr_idx;
   assign wr_data = r_wr_data;

endmodule

// File: tb/tb_i2c_target_mem.sv
// tb_i2c_target_mem: directed I2C master driving the target memory, table plus corner sequences.
module tb_i2c_target_mem;

   localparam int Q = 8;

   logic       clk;
   logic       rst;
   logic       m_scl;
   logic       m_sda;
   logic       sda_line;
   logic       sda_oe;
   logic       busy;
   logic       wr_stb;
   logic [7:0] wr_idx;
   logic [7:0] wr_data;
`ifdef I2C_TGT_WP_EN
   logic       wp;
`endif

   int n_run;
   int n_fail;
   int stb_cnt;
   int oe_cnt;
   int busy_cnt;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic [7:0]  exp_idx;
   } vec_t;

   vec_t tbl[4];

   assign sda_line = m_sda & ~sda_oe;

   i2c_target_mem #(
      .DEV_ADDR (7'h50),
      .AW       (8),
      .RST_VAL  (8'h00)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .scl_i   (m_scl),
      .sda_i   (sda_line),
      .sda_oe  (sda_oe),
      .busy    (busy),
      .wr_stb  (wr_stb),
      .wr_idx  (wr_idx),
      .wr_data (wr_data)
`ifdef I2C_TGT_WP_EN
      ,
      .wp      (wp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      stb_cnt  = 0;
      oe_cnt   = 0;
      busy_cnt = 0;
   end

   always @(posedge clk) begin
      if (wr_stb) stb_cnt++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic qwait();
      repeat (Q) @(negedge clk);
   endtask

   task automatic clk_bit(input logic b, output logic s);
      m_sda = b;
      qwait();
      m_scl = 1'b1;
      qwait();
      s = sda_line;
      qwait();
      m_scl = 1'b0;
      qwait();
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      qwait();
      m_scl = 1'b1;
      qwait();
      m_sda = 1'b0;
      qwait();
      m_scl = 1'b0;
      qwait();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      qwait();
      m_scl = 1'b1;
      qwait();
      m_sda = 1'b1;
      qwait();
   endtask

   // Returns 1 when the target pulled SDA low in the 9th clock.
   task automatic wr_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      ack = ~s;
   endtask

   task automatic send(input string nm, input logic [7:0] b,
                       input logic exp_ack);
      logic a;
      wr_byte(b, a);
      chk(nm, {15'd0, a}, {15'd0, exp_ack});
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         b[i] = s;
      end
      clk_bit(~mack, s);
   endtask

   task automatic set_addr(input string nm, input logic [15:0] a);
      i2c_start();
      send({nm, "_dev"}, 8'hA0, 1'b1);
      send({nm, "_ahi"}, a[15:8], 1'b1);
      send({nm, "_alo"}, a[7:0], 1'b1);
   endtask

   task automatic rd_check(input string nm, input logic mack,
                           input logic [7:0] exp);
      logic [7:0] b;
      rd_byte(mack, b);
      chk(nm, {8'd0, b}, {8'd0, exp});
   endtask

   initial begin
      int s0;
      int o0;
      int b0;
      logic s;

      n_run  = 0;
      n_fail = 0;
      m_scl  = 1'b1;
      m_sda  = 1'b1;
      rst    = 1'b1;
`ifdef I2C_TGT_WP_EN
      wp     = 1'b0;
`endif
      tbl[0] = '{addr: 16'h0000, data: 8'h12, exp_idx: 8'h00};
      tbl[1] = '{addr: 16'h0105, data: 8'h3C, exp_idx: 8'h05};
      tbl[2] = '{addr: 16'h0080, data: 8'hA5, exp_idx: 8'h80};
      tbl[3] = '{addr: 16'h00FE, data: 8'h7E, exp_idx: 8'hFE};

      repeat (4) @(negedge clk);
      chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
      chk("rst_wr_stb", {15'd0, wr_stb}, 16'd0);
      chk("rst_wr_idx", {8'd0, wr_idx}, 16'd0);
      chk("rst_wr_data", {8'd0, wr_data}, 16'd0);
      rst = 1'b0;
      qwait();

      for (int v = 0; v < 4; v++) begin
         s0 = stb_cnt;
         set_addr("tbl_w", tbl[v].addr);
         chk("tbl_busy", {15'd0, busy}, 16'd1);
         send("tbl_data", tbl[v].data, 1'b1);
         i2c_stop();
         chk("tbl_stb", 16'(stb_cnt - s0), 16'd1);
         chk("tbl_idx", {8'd0, wr_idx}, {8'd0, tbl[v].exp_idx});
         chk("tbl_wdata", {8'd0, wr_data}, {8'd0, tbl[v].data});
         chk("tbl_busy_end", {15'd0, busy}, 16'd0);
         set_addr("tbl_r", tbl[v].addr);
         i2c_start();
         send("tbl_rdev", 8'hA1, 1'b1);
         rd_check("tbl_rdata", 1'b0, tbl[v].data);
         i2c_stop();
      end

      // Sequential random read, then current-address read of the next byte.
      set_addr("seq_w", 16'h0005);
      send("seq_d0", 8'hAA, 1'b1);
      send("seq_d1", 8'hBB, 1'b1);
      send("seq_d2", 8'hCC, 1'b1);
      send("seq_d3", 8'h5A, 1'b1);
      i2c_stop();
      set_addr("seq_r", 16'h0005);
      i2c_start();
      send("seq_rdev", 8'hA1, 1'b1);
      rd_check("seq_r0", 1'b1, 8'hAA);
      rd_check("seq_r1", 1'b1, 8'hBB);
      rd_check("seq_r2", 1'b0, 8'hCC);
      chk("seq_nack_busy", {15'd0, busy}, 16'd0);
      i2c_stop();
      i2c_start();
      send("cur_dev", 8'hA1, 1'b1);
      rd_check("cur_rd_ptr8", 1'b0, 8'h5A);
      i2c_stop();

      // Wrong device address is ignored entirely.
      s0 = stb_cnt;
      o0 = oe_cnt;
      b0 = busy_cnt;
      i2c_start();
      send("bad_nack", 8'hA2, 1'b0);
      clk_bit(1'b0, s);
      clk_bit(1'b1, s);
      i2c_stop();
      chk("bad_oe", 16'(oe_cnt - o0), 16'd0);
      chk("bad_busy", 16'(busy_cnt - b0), 16'd0);
      chk("bad_stb", 16'(stb_cnt - s0), 16'd0);

      // Burst write wraps from the top of memory to index 0.
      s0 = stb_cnt;
      set_addr("wrap_w", 16'h00FF);
      send("wrap_d0", 8'h11, 1'b1);
      send("wrap_d1", 8'h22, 1'b1);
      i2c_stop();
      chk("wrap_stb", 16'(stb_cnt - s0), 16'd2);
      chk("wrap_idx", {8'd0, wr_idx}, 16'h0000);
      set_addr("wrap_r", 16'h00FF);
      i2c_start();
      send("wrap_rdev", 8'hA1, 1'b1);
      rd_check("wrap_rFF", 1'b1, 8'h11);
      rd_check("wrap_r00", 1'b0, 8'h22);
      i2c_stop();

      // Reset in the middle of a data byte.
      set_addr("rst_w", 16'h0010);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, s);
      chk("mid_busy", {15'd0, busy}, 16'd1);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_oe", {15'd0, sda_oe}, 16'd0);
      chk("mid_rst_busy", {15'd0, busy}, 16'd0);
      chk("mid_rst_idx", {8'd0, wr_idx}, 16'd0);
      rst = 1'b0;
      qwait();
      i2c_start();
      send("mid_rdev", 8'hA1, 1'b1);
      rd_check("mid_rd_rstval", 1'b0, 8'h00);
      i2c_stop();

`ifdef I2C_TGT_WP_EN
      s0 = stb_cnt;
      wp = 1'b1;
      set_addr("wp_w", 16'h0003);
      send("wp_nack", 8'h55, 1'b0);
      i2c_stop();
      wp = 1'b0;
      chk("wp_stb", 16'(stb_cnt - s0), 16'd0);
      set_addr("wp_r", 16'h0003);
      i2c_start();
      send("wp_rdev", 8'hA1, 1'b1);
      rd_check("wp_mem3", 1'b0, 8'h00);
      i2c_stop();
`endif

      qwait();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
